// File: rtl/alu_issue_arbiter_if.sv
// Bundle of the two issue ports, the ALU side-band and the result port.
interface alu_issue_arbiter_if #(
    parameter int unsigned width    = 32,
    parameter int unsigned tagWidth = 4
) ();
    logic                req0Valid;
    logic                req0Ready;
    logic [width-1:0]    req0Op1;
    logic [width-1:0]    req0Op2;
    logic [3:0]          req0Func;
    logic [tagWidth-1:0] req0Tag;

    logic                req1Valid;
    logic                req1Ready;
    logic [width-1:0]    req1Op1;
    logic [width-1:0]    req1Op2;
    logic [3:0]          req1Func;
    logic [tagWidth-1:0] req1Tag;

    logic [width-1:0]    aluIn1;
    logic [width-1:0]    aluIn2;
    logic [3:0]          aluFunc;
    logic [width-1:0]    aluOut;

    logic                resValid;
    logic                resReady;
    logic [width-1:0]    resData;
    logic                resPort;
    logic [tagWidth-1:0] resTag;
    logic                resErr;

    // Requesters, ALU model and result consumer.
    modport master (
        output req0Valid, req0Op1, req0Op2, req0Func, req0Tag,
        input  req0Ready,
        output req1Valid, req1Op1, req1Op2, req1Func, req1Tag,
        input  req1Ready,
        input  aluIn1, aluIn2, aluFunc,
        output aluOut,
        input  resValid, resData, resPort, resTag, resErr,
        output resReady
    );

    // The arbiter itself.
    modport slave (
        input  req0Valid, req0Op1, req0Op2, req0Func, req0Tag,
        output req0Ready,
        input  req1Valid, req1Op1, req1Op2, req1Func, req1Tag,
        output req1Ready,
        output aluIn1, aluIn2, aluFunc,
        input  aluOut,
        output resValid, resData, resPort, resTag, resErr,
        input  resReady
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin sharing of one ALU between two issue ports, with an issue
// register feeding the ALU and a result register capturing its output.
module alu_issue_arbiter #(
    parameter int unsigned width    = 32,
    parameter int unsigned tagWidth = 4
) (
    input  logic               clk,
    input  logic               rstN,
    alu_issue_arbiter_if.slave bus
);
    localparam logic [2:0] IllegalFunc = 3'b111;

    // Issue register
    logic                s1_valid;
    logic [width-1:0]    s1_op1;
    logic [width-1:0]    s1_op2;
    logic [3:0]          s1_func;
    logic [tagWidth-1:0] s1_tag;
    logic                s1_port;
    logic                last_grant;

    // Result register
    logic                res_valid;
    logic [width-1:0]    res_data;
    logic                res_port;
    logic [tagWidth-1:0] res_tag;
    logic                res_err;

    logic s2_load;
    logic s1_load;
    logic grant0;
    logic grant1;
    logic ready0;
    logic ready1;
    logic illegal;

    // Pipeline advance, round-robin grant and request readies.
    always_comb begin
        s2_load = s1_valid && (!res_valid || bus.resReady);
        s1_load = !s1_valid || s2_load;
        grant0  = 1'b0;
        grant1  = 1'b0;
        if (bus.req0Valid && bus.req1Valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = bus.req0Valid;
            grant1 = bus.req1Valid;
        end
        // Readies are held low while reset is asserted.
        ready0  = grant0 && s1_load && rstN;
        ready1  = grant1 && s1_load && rstN;
        illegal = (s1_func[2:0] == IllegalFunc);
    end

    // Issue register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_valid   <= 1'b0;
            s1_op1     <= '0;
            s1_op2     <= '0;
            s1_func    <= '0;
            s1_tag     <= '0;
            s1_port    <= 1'b0;
            last_grant <= 1'b1;
        end else if (ready0) begin
            s1_valid   <= 1'b1;
            s1_op1     <= bus.req0Op1;
            s1_op2     <= bus.req0Op2;
            s1_func    <= bus.req0Func;
            s1_tag     <= bus.req0Tag;
            s1_port    <= 1'b0;
            last_grant <= 1'b0;
        end else if (ready1) begin
            s1_valid   <= 1'b1;
            s1_op1     <= bus.req1Op1;
            s1_op2     <= bus.req1Op2;
            s1_func    <= bus.req1Func;
            s1_tag     <= bus.req1Tag;
            s1_port    <= 1'b1;
            last_grant <= 1'b1;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    // Result register; illegal functions return zero with the error flag.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_port  <= 1'b0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (s2_load) begin
            res_valid <= 1'b1;
            res_data  <= illegal ? '0 : bus.aluOut;
            res_port  <= s1_port;
            res_tag   <= s1_tag;
            res_err   <= illegal;
        end else if (bus.resReady) begin
            res_valid <= 1'b0;
        end
    end

    // Output drive.
    always_comb begin
        bus.req0Ready = ready0;
        bus.req1Ready = ready1;
        bus.aluIn1    = s1_op1;
        bus.aluIn2    = s1_op2;
        bus.aluFunc   = s1_func;
        bus.resValid  = res_valid;
        bus.resData   = res_data;
        bus.resPort   = res_port;
        bus.resTag    = res_tag;
        bus.resErr    = res_err;
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed table-driven bench for alu_issue_arbiter with a small ALU model.
module tb_alu_issue_arbiter;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    localparam logic [3:0] ADD  = 4'b0100;
    localparam logic [3:0] SUB  = 4'b1100;
    localparam logic [3:0] SLTU = 4'b0110;
    localparam logic [3:0] ILL  = 4'b0111;

    typedef struct {
        bit          do_reset;
        logic        r0v;
        logic [31:0] r0a, r0b;
        logic [3:0]  r0f;
        logic [3:0]  r0t;
        logic        r1v;
        logic [31:0] r1a, r1b;
        logic [3:0]  r1f;
        logic [3:0]  r1t;
        logic        rr;
        logic        e_rdy0, e_rdy1, e_rv;
        logic [31:0] e_data;
        logic        e_port;
        logic [3:0]  e_tag;
        logic        e_err;
    } vec_t;

    logic clk;
    logic rstN;
    int unsigned n_checks;
    int unsigned n_fail;
    vec_t vecs[$];

    alu_issue_arbiter_if #(.width(W), .tagWidth(TW)) ifc ();

    alu_issue_arbiter #(.width(W), .tagWidth(TW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ADD, SUB, SLTU; anything else returns op1^op2.
    always_comb begin
        case (ifc.aluFunc)
            ADD:     ifc.aluOut = ifc.aluIn1 + ifc.aluIn2;
            SUB:     ifc.aluOut = ifc.aluIn1 - ifc.aluIn2;
            SLTU:    ifc.aluOut = 32'(ifc.aluIn1 < ifc.aluIn2);
            default: ifc.aluOut = ifc.aluIn1 ^ ifc.aluIn2;
        endcase
    end

    function automatic vec_t mk(
        input bit rst,
        input logic r0v, input logic [31:0] r0a, input logic [31:0] r0b,
        input logic [3:0] r0f, input logic [3:0] r0t,
        input logic r1v, input logic [31:0] r1a, input logic [31:0] r1b,
        input logic [3:0] r1f, input logic [3:0] r1t,
        input logic rr,
        input logic e0, input logic e1, input logic ev, input logic [31:0] ed,
        input logic ep, input logic [3:0] et, input logic ee);
        vec_t v;
        v.do_reset = rst;
        v.r0v = r0v; v.r0a = r0a; v.r0b = r0b; v.r0f = r0f; v.r0t = r0t;
        v.r1v = r1v; v.r1a = r1a; v.r1b = r1b; v.r1f = r1f; v.r1t = r1t;
        v.rr = rr;
        v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_rv = ev; v.e_data = ed;
        v.e_port = ep; v.e_tag = et; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        ifc.req0Valid = 1'b0; ifc.req0Op1 = '0; ifc.req0Op2 = '0; ifc.req0Func = '0; ifc.req0Tag = '0;
        ifc.req1Valid = 1'b0; ifc.req1Op1 = '0; ifc.req1Op2 = '0; ifc.req1Func = '0; ifc.req1Tag = '0;
    endtask

    task automatic reset_dut();
        rstN = 1'b0;
        ifc.req0Valid = 1'b1;
        ifc.req1Valid = 1'b1;
        #1;
        check("rst req0Ready", 32'(ifc.req0Ready), 32'd0);
        check("rst req1Ready", 32'(ifc.req1Ready), 32'd0);
        @(posedge clk); #1;
        check("rst resValid", 32'(ifc.resValid), 32'd0);
        check("rst resData",  ifc.resData, 32'd0);
        check("rst resErr",   32'(ifc.resErr), 32'd0);
        check("rst aluFunc",  32'(ifc.aluFunc), 32'd0);
        check("rst aluIn1",   ifc.aluIn1, 32'd0);
        rstN = 1'b1;
        drive_idle();
    endtask

    task automatic run_row(input vec_t v, input int idx);
        if (v.do_reset) reset_dut();
        ifc.req0Valid = v.r0v; ifc.req0Op1 = v.r0a; ifc.req0Op2 = v.r0b;
        ifc.req0Func  = v.r0f; ifc.req0Tag = v.r0t;
        ifc.req1Valid = v.r1v; ifc.req1Op1 = v.r1a; ifc.req1Op2 = v.r1b;
        ifc.req1Func  = v.r1f; ifc.req1Tag = v.r1t;
        ifc.resReady  = v.rr;
        #1;
        check($sformatf("row%0d req0Ready", idx), 32'(ifc.req0Ready), 32'(v.e_rdy0));
        check($sformatf("row%0d req1Ready", idx), 32'(ifc.req1Ready), 32'(v.e_rdy1));
        check($sformatf("row%0d resValid", idx),  32'(ifc.resValid),  32'(v.e_rv));
        if (v.e_rv) begin
            check($sformatf("row%0d resData", idx), ifc.resData, v.e_data);
            check($sformatf("row%0d resPort", idx), 32'(ifc.resPort), 32'(v.e_port));
            check($sformatf("row%0d resTag", idx),  32'(ifc.resTag),  32'(v.e_tag));
            check($sformatf("row%0d resErr", idx),  32'(ifc.resErr),  32'(v.e_err));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstN     = 1'b0;
        ifc.resReady = 1'b1;
        drive_idle();

        // Single op after reset: 5+3 tag 2 on port 0.
        vecs.push_back(mk(1, 1,5,3,ADD,2,   0,0,0,0,0, 1, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,1,8,0,2,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,0,0,0,0,0));
        // Contention from reset: grants 0,1,0,1; results 2,5,2,5.
        vecs.push_back(mk(1, 1,1,1,ADD,3,   1,9,4,SUB,5, 1, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0, 1,1,1,ADD,3,   1,9,4,SUB,5, 1, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0, 1,1,1,ADD,3,   1,9,4,SUB,5, 1, 1,0,1,2,0,3,0));
        vecs.push_back(mk(0, 1,1,1,ADD,3,   1,9,4,SUB,5, 1, 0,1,1,5,1,5,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,1,2,0,3,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,1,5,1,5,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,0,0,0,0,0));
        // Backpressure: two accepts, stall, third accepted as resReady rises.
        vecs.push_back(mk(0, 0,0,0,0,0,     1,10,3,ADD,1, 0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,20,5,SUB,2, 0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,7,7,ADD,3,  0, 0,0,1,13,1,1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,7,7,ADD,3,  0, 0,0,1,13,1,1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,7,7,ADD,3,  1, 0,1,1,13,1,1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,    1, 0,0,1,15,1,2,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,    1, 0,0,1,14,1,3,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,    1, 0,0,0,0,0,0,0));
        // Illegal function masks data, then SLTU 1<2.
        vecs.push_back(mk(0, 1,9,2,ILL,6,   0,0,0,0,0, 1, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0, 1,1,2,SLTU,7,  0,0,0,0,0, 1, 1,0,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,1,0,0,6,1));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,1,1,0,7,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0, 1, 0,0,0,0,0,0,0));
        // Single-requester fairness on port 1, then contention goes to port 0.
        vecs.push_back(mk(0, 0,0,0,0,0,     1,1,1,ADD,1, 1, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,2,1,ADD,2, 1, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,3,1,ADD,3, 1, 0,1,1,2,1,1,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,4,1,ADD,4, 1, 0,1,1,3,1,2,0));
        vecs.push_back(mk(0, 1,100,0,ADD,9, 1,5,1,ADD,5, 1, 1,0,1,4,1,3,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     1,5,1,ADD,5, 1, 0,1,1,5,1,4,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,   1, 0,0,1,100,0,9,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,   1, 0,0,1,6,1,5,0));
        vecs.push_back(mk(0, 0,0,0,0,0,     0,0,0,0,0,   1, 0,0,0,0,0,0,0));

        foreach (vecs[i]) run_row(vecs[i], i);

        // Reset mid-flight: fill S1 and S2, reset, confirm flush and grant order.
        ifc.resReady = 1'b0;
        ifc.req0Valid = 1'b1; ifc.req0Op1 = 32'd3; ifc.req0Op2 = 32'd4;
        ifc.req0Func = ADD; ifc.req0Tag = 4'd1;
        #1;
        check("mf accept0 a", 32'(ifc.req0Ready), 32'd1);
        @(posedge clk); #1;
        ifc.req0Op1 = 32'd5; ifc.req0Op2 = 32'd5; ifc.req0Tag = 4'd2;
        #1;
        check("mf accept0 b", 32'(ifc.req0Ready), 32'd1);
        @(posedge clk); #1;
        check("mf full resValid", 32'(ifc.resValid), 32'd1);
        check("mf full resData",  ifc.resData, 32'd7);
        check("mf full ready0",   32'(ifc.req0Ready), 32'd0);
        check("mf full aluIn1",   ifc.aluIn1, 32'd5);
        check("mf full aluFunc",  32'(ifc.aluFunc), 32'(ADD));
        @(posedge clk); #1;
        check("mf hold resData",  ifc.resData, 32'd7);
        check("mf hold aluIn2",   ifc.aluIn2, 32'd5);
        rstN = 1'b0;
        ifc.req1Valid = 1'b1; ifc.req1Op1 = 32'd8; ifc.req1Op2 = 32'd2;
        ifc.req1Func = SUB; ifc.req1Tag = 4'd4;
        ifc.resReady = 1'b1;
        #1;
        check("mf rst ready0", 32'(ifc.req0Ready), 32'd0);
        check("mf rst ready1", 32'(ifc.req1Ready), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        check("mf post resValid", 32'(ifc.resValid), 32'd0);
        check("mf post aluFunc",  32'(ifc.aluFunc), 32'd0);
        check("mf post ready0",   32'(ifc.req0Ready), 32'd1);
        check("mf post ready1",   32'(ifc.req1Ready), 32'd0);
        @(posedge clk); #1;
        check("mf next ready1",   32'(ifc.req1Ready), 32'd1);
        check("mf next resValid", 32'(ifc.resValid), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        #1;
        check("mf drain resValid", 32'(ifc.resValid), 32'd1);
        check("mf drain resData",  ifc.resData, 32'd10);
        check("mf drain resPort",  32'(ifc.resPort), 32'd0);
        @(posedge clk); #1;
        check("mf drain2 resData", ifc.resData, 32'd6);
        check("mf drain2 resPort", 32'(ifc.resPort), 32'd1);
        check("mf drain2 resTag",  32'(ifc.resTag), 32'd4);
        @(posedge clk); #1;
        check("mf empty resValid", 32'(ifc.resValid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
